// File: rtl/data_memory_hs_if.sv
// Request/response bundle between the core memory stage (master) and data_memory_hs (slave).
interface data_memory_hs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_func3;
  logic [ADDR_BITS-1:0]  req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_hs.sv
// Data memory with valid/ready request port, hardware clear on reset and fixed-latency response.
// Optional DMEM_MISALIGN_CHECK_EN flags misaligned and illegal accesses on resp_err.
module data_memory_hs #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  data_memory_hs_if.slave    bus,
  output logic               init_done
);
  localparam int WORD_AW = ADDR_BITS - 2;
  localparam int DEPTH   = 1 << WORD_AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state_q, state_d;
  logic [WORD_AW-1:0]    cnt_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc;
  logic [WORD_AW-1:0]    widx;
  logic [1:0]            boff;
  logic [2:0]            f3;
  logic                  f3_legal;
  logic                  fault;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wlane;
  logic [DATA_WIDTH-1:0] rd_fmt;
  logic                  err_fmt;

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [2:0] fn,
                                                        input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (fn[1:0])
      2'b00:   load_extend = fn[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = fn[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extend = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    init_done     = 1'b0;
    case (state_q)
      CLEAR: if (&cnt_q) state_d = RUN;
      RUN: begin
        bus.req_ready = 1'b1;
        init_done     = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign acc  = bus.req_valid & bus.req_ready;
  assign widx = bus.req_addr[ADDR_BITS-1:2];
  assign boff = bus.req_addr[1:0];
  assign f3   = bus.req_func3;

  // Request decode: legality, lane enables and formatted load data, all resolved at accept
  always_comb begin
    f3_legal = bus.req_we ? (f3 <= 3'b010) : !((f3 == 3'b011) || (f3[2:1] == 2'b11));
`ifdef DMEM_MISALIGN_CHECK_EN
    fault    = !f3_legal || ((f3[1:0] == 2'b01) && boff[0])
                         || ((f3[1:0] == 2'b10) && (boff != 2'b00));
    err_fmt  = fault;
`else
    fault    = !f3_legal;
    err_fmt  = 1'b0;
`endif
    case (f3[1:0])
      2'b00:   begin be = 4'b0001 << boff;                      wlane = {4{bus.req_wdata[7:0]}};  end
      2'b01:   begin be = boff[1] ? 4'b1100 : 4'b0011;          wlane = {2{bus.req_wdata[15:0]}}; end
      2'b10:   begin be = 4'b1111;                              wlane = bus.req_wdata;            end
      default: begin be = 4'b0000;                              wlane = bus.req_wdata;            end
    endcase
    if (!acc || !bus.req_we || fault) be = 4'b0000;
    rd_fmt = load_extend(mem[widx], f3, boff);
    if (bus.req_we || fault) rd_fmt = '0;
  end

  // Array update: clear sweep in CLEAR, lane-masked stores in RUN
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

  // Response pipeline: stage 0 loads on the accept edge, last stage drives the port
  for (genvar i = 0; i < READ_LATENCY; i++) begin : g_pipe
    logic                  vld_in;
    logic [DATA_WIDTH-1:0] rdata_in;
    logic                  err_in;
    logic                  vld_p;
    logic [DATA_WIDTH-1:0] rdata_p;
    logic                  err_p;

    if (i == 0) begin : g_head
      assign vld_in   = acc;
      assign rdata_in = rd_fmt;
      assign err_in   = err_fmt;
    end else begin : g_body
      assign vld_in   = g_pipe[i-1].vld_p;
      assign rdata_in = g_pipe[i-1].rdata_p;
      assign err_in   = g_pipe[i-1].err_p;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vld_p <= 1'b0;
      else          vld_p <= vld_in;
    end

    if (i == READ_LATENCY - 1) begin : g_tail
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdata_p <= '0;
          err_p   <= 1'b0;
        end else if (vld_in) begin
          rdata_p <= rdata_in;
          err_p   <= err_in;
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (vld_in) begin
          rdata_p <= rdata_in;
          err_p   <= err_in;
        end
      end
    end
  end

  assign bus.resp_valid = g_pipe[READ_LATENCY-1].vld_p;
  assign bus.resp_rdata = g_pipe[READ_LATENCY-1].rdata_p;
  assign bus.resp_err   = g_pipe[READ_LATENCY-1].err_p;
endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: directed cases plus randomized traffic against a byte-array model.
module tb_data_memory_hs;
  localparam int AB    = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << (AB - 2);

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic init_done;

  data_memory_hs_if #(.DATA_WIDTH(32), .ADDR_BITS(AB)) bus ();

  data_memory_hs #(.DATA_WIDTH(32), .ADDR_BITS(AB), .READ_LATENCY(LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        expq[$];
  logic [7:0]  mm [1 << AB];
  logic [31:0] last_rd = '0;
  logic        last_er = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour over a flat little-endian byte array
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [AB-1:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int          nb, ai, ea;
    logic        legal;
    logic [31:0] v;
    rd    = '0;
    er    = 1'b0;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) begin
`ifdef DMEM_MISALIGN_CHECK_EN
      er = 1'b1;
`endif
      return;
    end
    nb = 1 << f3[1:0];
    ai = int'(a);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((ai % nb) != 0) begin
      er = 1'b1;
      return;
    end
`endif
    ea = ai - (ai % nb);
    if (we) begin
      for (int k = 0; k < nb; k++) mm[ea + k] = wd[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < nb; k++) v = v | ({24'b0, mm[ea + k]} << (8 * k));
      if (!f3[2] && nb < 4 && v[8*nb - 1]) v = v | ~((32'h1 << (8 * nb)) - 1);
      rd = v;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [AB-1:0] a,
                       input logic [31:0] wd, input bit kchk = 1'b0,
                       input logic [31:0] krd = '0, input logic ker = 1'b0);
    logic        rdy;
    int          c;
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_func3 = f3;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    rdy = bus.req_ready;
    c   = cyc;
    @(posedge clk);
    if (rdy) begin
      model_access(we, f3, a, wd, rd, er);
      e.due   = c + LAT;
      e.rdata = kchk ? krd : rd;
      e.err   = kchk ? ker : er;
      expq.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AB'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input int hold);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    expq.delete();
    last_rd = '0;
    last_er = 1'b0;
    foreach (mm[i]) mm[i] = 8'h00;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    repeat (hold) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Requests held during the clear must be ignored; ready rises after exactly DEPTH edges
  task automatic wait_init();
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'b010;
    bus.req_addr  = AB'(10'h3FC);
    while (!bus.req_ready && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("clear_cycles", n, DEPTH);
    chk("init_done", init_done, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        chk("resp_valid", bus.resp_valid, 1);
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", bus.resp_err, e.err);
        last_rd = e.rdata;
        last_er = e.err;
      end else begin
        chk("resp_idle", bus.resp_valid, 0);
        chk("rdata_hold", bus.resp_rdata, last_rd);
        chk("err_hold", bus.resp_err, last_er);
      end
    end
  end

  initial begin
    logic          we;
    logic [2:0]    f3;
    logic [AB-1:0] a;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    apply_reset(3);
    wait_init();
    issue(1'b0, 3'b010, AB'(10'h3FC), 32'h0, 1'b1, 32'h0000_0000, 1'b0);

    issue(1'b1, 3'b010, AB'(10'h100), 32'h8081_7F01);
    issue(1'b0, 3'b000, AB'(10'h100), 32'h0, 1'b1, 32'h0000_0001, 1'b0);
    issue(1'b0, 3'b100, AB'(10'h101), 32'h0, 1'b1, 32'h0000_007F, 1'b0);
    issue(1'b0, 3'b000, AB'(10'h103), 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'b101, AB'(10'h102), 32'h0, 1'b1, 32'h0000_8081, 1'b0);

    issue(1'b1, 3'b010, AB'(10'h040), 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, AB'(10'h040), 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 3'b000, AB'(10'h041), 32'h0000_0055);
    issue(1'b0, 3'b010, AB'(10'h040), 32'h0, 1'b1, 32'hDEAD_55EF, 1'b0);

    issue(1'b1, 3'b010, AB'(10'h000), 32'hCAFE_F00D);
`ifdef DMEM_MISALIGN_CHECK_EN
    issue(1'b1, 3'b010, AB'(10'h002), 32'h1234_5678, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 3'b010, AB'(10'h000), 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, 3'b001, AB'(10'h001), 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 3'b011, AB'(10'h000), 32'h1111_1111, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 3'b110, AB'(10'h000), 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 3'b010, AB'(10'h000), 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
`else
    issue(1'b1, 3'b001, AB'(10'h003), 32'h0000_ABCD, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 3'b010, AB'(10'h000), 32'h0, 1'b1, 32'hABCD_F00D, 1'b0);
    issue(1'b1, 3'b011, AB'(10'h000), 32'h1111_1111, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 3'b110, AB'(10'h000), 32'h0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 3'b010, AB'(10'h001), 32'h0, 1'b1, 32'hABCD_F00D, 1'b0);
`endif

    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 9) < 8) begin
        we = 1'($urandom);
        f3 = 3'($urandom_range(0, 7));
        a  = ($urandom_range(0, 1) == 1) ? AB'($urandom_range(0, 31)) : AB'($urandom);
        issue(we, f3, a, $urandom);
      end else begin
        idle();
      end
    end

    issue(1'b0, 3'b010, AB'(10'h040), 32'h0);
    apply_reset(2);
    repeat (99) @(negedge clk);
    apply_reset(2);
    wait_init();
    issue(1'b0, 3'b010, AB'(10'h040), 32'h0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 3'b010, AB'(10'h100), 32'h0, 1'b1, 32'h0, 1'b0);

    repeat (LAT + 2) @(negedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
